// File: rtl/cache_data_pkg.sv
// ---------------------------------------------------------------------------
// cache_data_pkg
// Shared definitions for the set-associative cache data array:
//   - fill_state_t : block-fill engine states (IDLE, FILL, DONE)
//   - idx_width()  : clog2 with a floor of 1, used for every index width
//   - DEF_*        : index widths derived from the default geometry
//   - even_parity(): parity bit stored next to each word when the
//                    CACHE_DATA_PARITY_EN build option is defined
// ---------------------------------------------------------------------------
package cache_data_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // Index width for a table of n entries; a 1-entry table still gets a
    // 1-bit index so that port widths never collapse to zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WAYS    = 2;
    localparam int DEF_SETS    = 64;
    localparam int DEF_WORDS   = 8;
    localparam int DEF_SET_W   = idx_width(DEF_SETS);
    localparam int DEF_WIDX_W  = idx_width(DEF_WORDS);
    localparam int DEF_WAY_W   = idx_width(DEF_WAYS);

    // Widest data word the parity helper accepts; callers zero-extend,
    // which leaves the parity unchanged.
    localparam int PAR_MAX_W   = 256;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cache_data_way.sv
// ---------------------------------------------------------------------------
// cache_data_way
// Flop-based storage of one cache way: SETS sets x WORDS words x STORE_W bits.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all words)
//   i_we                write enable
//   i_wr_set/i_wr_word  write address
//   i_wr_data           write data (STORE_W bits, may include a parity bit)
//   i_rd_set/i_rd_word  read address
//   o_rd_data           combinational read of the addressed word
// ---------------------------------------------------------------------------
module cache_data_way
    import cache_data_pkg::*;
#(
    parameter int SETS    = DEF_SETS,
    parameter int WORDS   = DEF_WORDS,
    parameter int STORE_W = 16,
    parameter int SET_W   = idx_width(SETS),
    parameter int WIDX_W  = idx_width(WORDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [SET_W-1:0]   i_wr_set,
    input  logic [WIDX_W-1:0]  i_wr_word,
    input  logic [STORE_W-1:0] i_wr_data,
    input  logic [SET_W-1:0]   i_rd_set,
    input  logic [WIDX_W-1:0]  i_rd_word,
    output logic [STORE_W-1:0] o_rd_data
);

    // {set, word} concatenation is the flat address; sizing the array to the
    // full address range keeps every index in bounds.
    localparam int ADDR_W = SET_W + WIDX_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [STORE_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [ADDR_W-1:0]  w_rd_addr;

    assign w_wr_addr = {i_wr_set, i_wr_word};
    assign w_rd_addr = {i_rd_set, i_rd_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    // Read sees the array before this cycle's write; the top level registers it.
    assign o_rd_data = r_mem[w_rd_addr];

endmodule

// File: rtl/cache_data_array_nway.sv
// ---------------------------------------------------------------------------
// cache_data_array_nway
// Set-associative cache data store: WAYS x SETS x WORDS x DATA_W, flop based.
// Build option: CACHE_DATA_PARITY_EN adds a stored even-parity bit per word,
// output o_rd_perr and fault-injection input i_test_flip.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_rd_en, i_rd_set, i_rd_word     read request (all ways in parallel)
//   o_rd_valid, o_rd_data            registered read, one cycle after i_rd_en;
//                                    way i in o_rd_data[i*DATA_W +: DATA_W]
//   i_wr_en, i_wr_set, i_wr_way,
//   i_wr_word, i_wr_data, o_wr_ready single-word write, accepted when !busy
//   i_fill_start, i_fill_set,
//   i_fill_way                       start a block fill (sampled in IDLE)
//   i_fill_valid, i_fill_data,
//   o_fill_ready                     one beat per accepted cycle
//   o_fill_done                      one-cycle pulse after the last beat
//   o_busy                           fill in progress
//   o_rd_perr, i_test_flip           parity build only
// ---------------------------------------------------------------------------
module cache_data_array_nway
    import cache_data_pkg::*;
#(
    parameter int  WAYS   = DEF_WAYS,
    parameter int  SETS   = DEF_SETS,
    parameter int  WORDS  = DEF_WORDS,
    parameter int  DATA_W = 16,
    localparam int SET_W  = idx_width(SETS),
    localparam int WIDX_W = idx_width(WORDS),
    localparam int WAY_W  = idx_width(WAYS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_rd_en,
    input  logic [SET_W-1:0]       i_rd_set,
    input  logic [WIDX_W-1:0]      i_rd_word,
    output logic                   o_rd_valid,
    output logic [WAYS*DATA_W-1:0] o_rd_data,
    input  logic                   i_wr_en,
    input  logic [SET_W-1:0]       i_wr_set,
    input  logic [WAY_W-1:0]       i_wr_way,
    input  logic [WIDX_W-1:0]      i_wr_word,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic                   o_wr_ready,
    input  logic                   i_fill_start,
    input  logic [SET_W-1:0]       i_fill_set,
    input  logic [WAY_W-1:0]       i_fill_way,
    input  logic                   i_fill_valid,
    input  logic [DATA_W-1:0]      i_fill_data,
    output logic                   o_fill_ready,
    output logic                   o_fill_done,
`ifdef CACHE_DATA_PARITY_EN
    output logic [WAYS-1:0]        o_rd_perr,
    input  logic                   i_test_flip,
`endif
    output logic                   o_busy
);

`ifdef CACHE_DATA_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif

    fill_state_t              r_state;
    fill_state_t              w_state_next;
    logic [WIDX_W-1:0]        r_cnt;
    logic [WIDX_W-1:0]        w_cnt_next;
    logic [SET_W-1:0]         r_fill_set;
    logic [WAY_W-1:0]         r_fill_way;
    logic                     w_latch_fill;
    logic                     w_fill_beat;
    logic [WAYS*DATA_W-1:0]   w_rd_all;
    logic                     r_rd_valid;
    logic [WAYS*DATA_W-1:0]   r_rd_data;
`ifdef CACHE_DATA_PARITY_EN
    logic [WAYS-1:0]          w_perr;
    logic [WAYS-1:0]          r_rd_perr;
`endif

    // ---------------- fill FSM: next state and outputs ----------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch_fill = 1'b0;
        w_fill_beat  = 1'b0;
        o_busy       = 1'b0;
        o_fill_ready = 1'b0;
        o_fill_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_fill_start) begin
                    w_latch_fill = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                o_busy       = 1'b1;
                o_fill_ready = 1'b1;
                if (i_fill_valid) begin
                    w_fill_beat = 1'b1;
                    // Counter stops at the last word rather than wrapping.
                    if (r_cnt == WIDX_W'(WORDS - 1)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                o_fill_done  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_fill_set <= '0;
            r_fill_way <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_latch_fill) begin
                r_fill_set <= i_fill_set;
                r_fill_way <= i_fill_way;
            end
        end
    end

    // Single-word writes only land outside FILL, so they never collide with
    // a fill beat in the same way.
    assign o_wr_ready = ~o_busy;

    // ---------------- per-way storage and write steering ----------------
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic               w_wr_sel;
        logic               w_fill_sel;
        logic [SET_W-1:0]   w_set;
        logic [WIDX_W-1:0]  w_word;
        logic [DATA_W-1:0]  w_data;
        logic [STORE_W-1:0] w_store;
        logic [STORE_W-1:0] w_rd_word;

        // Way indices >= WAYS match no instance and so write nothing.
        assign w_wr_sel   = i_wr_en & o_wr_ready & (i_wr_way == WAY_W'(gi));
        assign w_fill_sel = w_fill_beat & (r_fill_way == WAY_W'(gi));
        assign w_set      = w_fill_sel ? r_fill_set  : i_wr_set;
        assign w_word     = w_fill_sel ? r_cnt       : i_wr_word;
        assign w_data     = w_fill_sel ? i_fill_data : i_wr_data;

`ifdef CACHE_DATA_PARITY_EN
        assign w_store = {even_parity(PAR_MAX_W'(w_data)) ^ i_test_flip, w_data};
        // Stored word plus its parity bit must have an even count of ones.
        assign w_perr[gi] = ^w_rd_word;
`else
        assign w_store = w_data;
`endif

        cache_data_way #(
            .SETS    (SETS),
            .WORDS   (WORDS),
            .STORE_W (STORE_W),
            .SET_W   (SET_W),
            .WIDX_W  (WIDX_W)
        ) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_we      (w_wr_sel | w_fill_sel),
            .i_wr_set  (w_set),
            .i_wr_word (w_word),
            .i_wr_data (w_store),
            .i_rd_set  (i_rd_set),
            .i_rd_word (i_rd_word),
            .o_rd_data (w_rd_word)
        );

        assign w_rd_all[gi*DATA_W +: DATA_W] = w_rd_word[DATA_W-1:0];
    end

    // ---------------- read register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
`ifdef CACHE_DATA_PARITY_EN
            r_rd_perr  <= '0;
`endif
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_rd_all;
            end
`ifdef CACHE_DATA_PARITY_EN
            r_rd_perr <= i_rd_en ? w_perr : '0;
`endif
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
`ifdef CACHE_DATA_PARITY_EN
    assign o_rd_perr  = r_rd_perr;
`endif

endmodule

// File: tb/tb_cache_data_array_nway.sv
// ---------------------------------------------------------------------------
// tb_cache_data_array_nway
// Directed test of cache_data_array_nway at default geometry
// (2 ways x 64 sets x 8 words x 16 bits). Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
// ---------------------------------------------------------------------------
module tb_cache_data_array_nway;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [5:0]  rd_set;
    logic [2:0]  rd_word;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [5:0]  wr_set;
    logic [0:0]  wr_way;
    logic [2:0]  wr_word;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        fill_start;
    logic [5:0]  fill_set;
    logic [0:0]  fill_way;
    logic        fill_valid;
    logic [15:0] fill_data;
    logic        fill_ready;
    logic        fill_done;
    logic        busy;
`ifdef CACHE_DATA_PARITY_EN
    logic [1:0]  rd_perr;
    logic        test_flip;
`endif

    int n_cmp;
    int n_bad;

    cache_data_array_nway dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rd_en      (rd_en),
        .i_rd_set     (rd_set),
        .i_rd_word    (rd_word),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .i_wr_en      (wr_en),
        .i_wr_set     (wr_set),
        .i_wr_way     (wr_way),
        .i_wr_word    (wr_word),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .i_fill_start (fill_start),
        .i_fill_set   (fill_set),
        .i_fill_way   (fill_way),
        .i_fill_valid (fill_valid),
        .i_fill_data  (fill_data),
        .o_fill_ready (fill_ready),
        .o_fill_done  (fill_done),
`ifdef CACHE_DATA_PARITY_EN
        .o_rd_perr    (rd_perr),
        .i_test_flip  (test_flip),
`endif
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[tb] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [5:0] s,
                              input logic [2:0] w, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_set  = s;
        rd_word = w;
        tick();
        rd_en = 1'b0;
        check_value({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check_value({tag, "_data"}, rd_data, exp);
    endtask

    task automatic send_beat(input logic [15:0] d);
        fill_valid = 1'b1;
        fill_data  = d;
        tick();
        fill_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        rd_en = 1'b0; rd_set = '0; rd_word = '0;
        wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_word = '0; wr_data = '0;
        fill_start = 1'b0; fill_set = '0; fill_way = '0;
        fill_valid = 1'b0; fill_data = '0;
`ifdef CACHE_DATA_PARITY_EN
        test_flip = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check_value("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_value("rst_rd_data", rd_data, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_fill_ready", {31'd0, fill_ready}, 32'd0);
        check_value("rst_fill_done", {31'd0, fill_done}, 32'd0);
        check_value("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Read of zeroed storage.
        read_check("rd_zero", 6'd5, 3'd3, 32'h0000_0000);
        tick();
        check_value("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Single write with same-cycle read (read-before-write).
        wr_en = 1'b1; wr_set = 6'd5; wr_way = 1'b1; wr_word = 3'd3; wr_data = 16'hBEEF;
        check_value("wr_ready_idle", {31'd0, wr_ready}, 32'd1);
        read_check("rd_before_wr", 6'd5, 3'd3, 32'h0000_0000);
        wr_en = 1'b0;
        read_check("rd_after_wr", 6'd5, 3'd3, 32'hBEEF_0000);
        tick();
        check_value("rd_data_hold", rd_data, 32'hBEEF_0000);

        // Fill set 10 way 0 with two stall cycles after the fourth beat,
        // a write held across the fill, and a read in the middle.
        fill_start = 1'b1; fill_set = 6'd10; fill_way = 1'b0;
        tick();
        fill_start = 1'b0;
        check_value("fill_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_value("fill_ready", {31'd0, fill_ready}, 32'd1);
            send_beat(16'(16'h1000 + i));
            if (i == 3) begin
                wr_en = 1'b1; wr_set = 6'd20; wr_way = 1'b1; wr_word = 3'd2;
                wr_data = 16'hDEAD;
                for (int k = 0; k < 2; k++) begin
                    check_value("stall_busy", {31'd0, busy}, 32'd1);
                    check_value("stall_wr_ready", {31'd0, wr_ready}, 32'd0);
                    rd_en = (k == 1); rd_set = 6'd20; rd_word = 3'd2;
                    tick();
                    rd_en = 1'b0;
                end
                check_value("wr_dropped", rd_data, 32'h0000_0000);
            end
            if (i < 7) begin
                check_value("fill_no_done", {31'd0, fill_done}, 32'd0);
            end
        end
        check_value("done_pulse", {31'd0, fill_done}, 32'd1);
        check_value("done_busy", {31'd0, busy}, 32'd0);
        check_value("done_wr_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_en = 1'b0;
        check_value("done_one_cycle", {31'd0, fill_done}, 32'd0);
        check_value("idle_busy", {31'd0, busy}, 32'd0);
        read_check("held_wr", 6'd20, 3'd2, 32'hDEAD_0000);
        for (int i = 0; i < 8; i++) begin
            read_check("fill10", 6'd10, 3'(i), {16'h0000, 16'(16'h1000 + i)});
        end

        // fill_start together with a write to the same block.
        fill_start = 1'b1; fill_set = 6'd30; fill_way = 1'b1;
        wr_en = 1'b1; wr_set = 6'd30; wr_way = 1'b1; wr_word = 3'd5; wr_data = 16'h5555;
        check_value("sim_wr_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        fill_start = 1'b0; wr_en = 1'b0;
        check_value("sim_busy", {31'd0, busy}, 32'd1);
        read_check("sim_wr_landed", 6'd30, 3'd5, 32'h5555_0000);
        for (int i = 0; i < 8; i++) begin
            send_beat(16'(16'h2000 + i));
        end
        check_value("sim_done", {31'd0, fill_done}, 32'd1);
        tick();
        read_check("sim_overwrite", 6'd30, 3'd5, 32'h2005_0000);

        // Reset in the middle of a fill.
        fill_start = 1'b1; fill_set = 6'd40; fill_way = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat(16'(16'h4000 + i));
        end
        check_value("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_value("mid_rst_fill_ready", {31'd0, fill_ready}, 32'd0);
        check_value("mid_rst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            read_check("rst_cleared40", 6'd40, 3'(i), 32'h0000_0000);
        end
        read_check("rst_cleared5", 6'd5, 3'd3, 32'h0000_0000);
        read_check("rst_cleared10", 6'd10, 3'd7, 32'h0000_0000);
        fill_start = 1'b1; fill_set = 6'd40; fill_way = 1'b1;
        tick();
        fill_start = 1'b0;
        check_value("refill_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_beat(16'(16'h3000 + i));
        end
        check_value("refill_done", {31'd0, fill_done}, 32'd1);
        tick();
        read_check("refill_w0", 6'd40, 3'd0, 32'h3000_0000);
        read_check("refill_w7", 6'd40, 3'd7, 32'h3007_0000);

`ifdef CACHE_DATA_PARITY_EN
        wr_en = 1'b1; wr_set = 6'd1; wr_way = 1'b0; wr_word = 3'd0; wr_data = 16'h00FF;
        test_flip = 1'b1;
        tick();
        wr_en = 1'b0; test_flip = 1'b0;
        read_check("par_flip", 6'd1, 3'd0, 32'h0000_00FF);
        check_value("perr_flip", {30'd0, rd_perr}, 32'h1);
        tick();
        check_value("perr_idle", {30'd0, rd_perr}, 32'h0);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        read_check("par_clean", 6'd1, 3'd0, 32'h0000_00FF);
        check_value("perr_clean", {30'd0, rd_perr}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
